// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, key schedule run backwards (K16 first).
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; a raised valid holds its payload until then.
`timescale 1ns/1ps
module des_decrypt_core #(
  parameter int OUT_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // S-box n, entry (row*16 + col) at nibble [255-4*idx -: 4]
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    x = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      s[31-4*j -: 4] = SBOX[j][255 - 4*int'({b[5], b[0], b[4:1]}) -: 4];
    end
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_round_cnt;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic [27:0] w_c_rot, w_d_rot;
  logic [63:0] w_fp;
  logic        w_accept, w_out_fire;

  // Undo the encryption left shifts: none before K16, one step before K15/K8/K1.
  always_comb begin
    w_c_rot = r_c;
    w_d_rot = r_d;
    if (r_round_cnt == 5'd2 || r_round_cnt == 5'd9 || r_round_cnt == 5'd16) begin
      w_c_rot = {r_c[0], r_c[27:1]};
      w_d_rot = {r_d[0], r_d[27:1]};
    end else if (r_round_cnt != 5'd1) begin
      w_c_rot = {r_c[1:0], r_c[27:2]};
      w_d_rot = {r_d[1:0], r_d[27:2]};
    end
  end

  assign w_fp       = perm_fp({r_r, r_l});
  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_ROUND;
      S_ROUND: if (r_round_cnt == 5'd16) w_state_nxt = S_DONE;
      S_DONE:  if (w_out_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_round_cnt <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        {r_l, r_r}  <= perm_ip(in_data);
        {r_c, r_d}  <= perm_pc1(in_key);
        r_round_cnt <= 5'd1;
      end else if (r_state == S_ROUND) begin
        r_l <= r_r;
        r_r <= r_l ^ f_func(r_r, perm_pc2({w_c_rot, w_d_rot}));
        r_c <= w_c_rot;
        r_d <= w_d_rot;
        if (r_round_cnt != 5'd16) r_round_cnt <= r_round_cnt + 5'd1;
      end else if (r_state == S_DONE && w_out_fire) begin
        r_round_cnt <= '0;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic        r_out_valid;
    logic [63:0] r_out_data;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else if (r_state == S_DONE && !r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_fp;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
  end else begin : g_out_comb
    assign out_valid = (r_state == S_DONE);
    assign out_data  = w_fp;
  end

endmodule
